// File: rtl/fir_sched_pkg.sv
// Shared types and constants for the FIR stream scheduler.
// The optional watchdog is enabled by defining FIR_SCHED_WDOG_EN.
package fir_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

  localparam int ERR_TLAST = 0;
  localparam int ERR_WDOG  = 1;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_LEN_WIDTH   = 32;
  localparam int DEF_WDOG_CYCLES = 1024;

endpackage

// File: rtl/fir_sched_cnt.sv
// Sample counter compared against a programmed length; it stops at the length,
// and reports whether more samples are allowed and whether the next one is the last.
module fir_sched_cnt
  import fir_sched_pkg::*;
#(
  parameter int W = DEF_LEN_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_len,
  output logic [W-1:0] o_cnt,
  output logic         o_en,
  output logic         o_last
);

  logic [W-1:0] r_cnt;
  logic         w_en;

  assign w_en   = (r_cnt < i_len);
  assign o_en   = w_en;
  assign o_last = w_en & (r_cnt == i_len - W'(1));
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && w_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/fir_stream_sched.sv
// Run-state gating of the X/Y streams around the FIR core, with ap_* status and
// tlast checking. Define FIR_SCHED_WDOG_EN to build the idle watchdog.
//
// state   | meaning
// IDLE    | waiting for a start with a non-zero length; streams gated off
// RUN     | X and Y pass through until len samples have gone each way
// DONE    | job finished; ap_done held until a status read or a new start
module fir_stream_sched
  import fir_sched_pkg::*;
#(
  parameter int pDATA_WIDTH = DEF_DATA_WIDTH,
  parameter int pLEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic [pLEN_WIDTH-1:0]  cfg_len,
  input  logic                   done_clr,
  output logic                   ap_start,
  output logic                   ap_idle,
  output logic                   ap_done,
  output logic [1:0]             err,
  input  logic                   us_tvalid,
  output logic                   us_tready,
  input  logic [pDATA_WIDTH-1:0] us_tdata,
  output logic                   fir_ss_tvalid,
  input  logic                   fir_ss_tready,
  output logic [pDATA_WIDTH-1:0] fir_ss_tdata,
  output logic                   fir_ss_tlast,
  input  logic                   fir_sm_tvalid,
  output logic                   fir_sm_tready,
  input  logic [pDATA_WIDTH-1:0] fir_sm_tdata,
  input  logic                   fir_sm_tlast,
  output logic                   ds_tvalid,
  input  logic                   ds_tready,
  output logic [pDATA_WIDTH-1:0] ds_tdata,
  output logic [pLEN_WIDTH-1:0]  x_cnt,
  output logic [pLEN_WIDTH-1:0]  y_cnt
);

  sched_state_t          r_state, w_state_nxt;
  logic [pLEN_WIDTH-1:0] r_len;
  logic                  r_ap_start;
  logic [1:0]            r_err;

  logic w_run, w_start_ok;
  logic w_x_en, w_x_last, w_x_gate, w_x_hs;
  logic w_y_en, w_y_last, w_y_gate, w_y_hs;
  logic w_wdog_hit;

  assign w_run      = (r_state == ST_RUN);
  assign w_start_ok = cfg_start && (cfg_len != '0) && (r_state != ST_RUN);

  assign w_x_gate = w_run & w_x_en;
  assign w_y_gate = w_run & w_y_en;
  assign w_x_hs   = us_tvalid & fir_ss_tready & w_x_gate;
  assign w_y_hs   = fir_sm_tvalid & ds_tready & w_y_gate;

  assign fir_ss_tvalid = us_tvalid & w_x_gate;
  assign us_tready     = fir_ss_tready & w_x_gate;
  assign fir_ss_tdata  = us_tdata;
  assign fir_ss_tlast  = w_run & w_x_last;

  assign ds_tvalid     = fir_sm_tvalid & w_y_gate;
  assign fir_sm_tready = ds_tready & w_y_gate;
  assign ds_tdata      = fir_sm_tdata;

  assign ap_start = r_ap_start;
  assign ap_idle  = (r_state != ST_RUN);
  assign ap_done  = (r_state == ST_DONE);
  assign err      = r_err;

  fir_sched_cnt #(.W(pLEN_WIDTH)) u_x_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start_ok),
    .i_inc  (w_x_hs),
    .i_len  (r_len),
    .o_cnt  (x_cnt),
    .o_en   (w_x_en),
    .o_last (w_x_last)
  );

  fir_sched_cnt #(.W(pLEN_WIDTH)) u_y_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start_ok),
    .i_inc  (w_y_hs),
    .i_len  (r_len),
    .o_cnt  (y_cnt),
    .o_en   (w_y_en),
    .o_last (w_y_last)
  );

`ifdef FIR_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] r_wdog;

  always_ff @(posedge clk) begin
    if (rst || !w_run || w_x_hs || w_y_hs) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end
  end

  // Fires on the WDOG_CYCLES-th consecutive idle cycle in RUN.
  assign w_wdog_hit = w_run & ~(w_x_hs | w_y_hs) & (r_wdog == WDOG_W'(WDOG_CYCLES - 1));
`else
  logic w_unused_wdog;
  assign w_unused_wdog = (WDOG_CYCLES != 0);
  assign w_wdog_hit    = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_state_nxt = ST_RUN;
      ST_RUN:  if ((w_y_hs && w_y_last) || w_wdog_hit) w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (w_start_ok)    w_state_nxt = ST_RUN;
        else if (done_clr) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_ap_start <= 1'b0;
      r_err      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_len      <= cfg_len;
        r_ap_start <= 1'b1;
        r_err      <= '0;
      end else begin
        if (w_x_hs) r_ap_start <= 1'b0;
        if (w_y_hs && (fir_sm_tlast != w_y_last)) r_err[ERR_TLAST] <= 1'b1;
        if (w_wdog_hit) r_err[ERR_WDOG] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_sched.sv
// Scoreboard bench for fir_stream_sched; the bench also plays the FIR core.
// Watchdog scenario is compiled in when FIR_SCHED_WDOG_EN is defined.
module tb_fir_stream_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start, done_clr;
  logic [31:0] cfg_len;
  logic        ap_start, ap_idle, ap_done;
  logic [1:0]  err;
  logic        us_tvalid, us_tready;
  logic [31:0] us_tdata;
  logic        fir_ss_tvalid, fir_ss_tready, fir_ss_tlast;
  logic [31:0] fir_ss_tdata;
  logic        fir_sm_tvalid, fir_sm_tready, fir_sm_tlast;
  logic [31:0] fir_sm_tdata;
  logic        ds_tvalid, ds_tready;
  logic [31:0] ds_tdata;
  logic [31:0] x_cnt, y_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fir_stream_sched #(.pDATA_WIDTH(32), .pLEN_WIDTH(32), .WDOG_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len), .done_clr(done_clr),
    .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done), .err(err),
    .us_tvalid(us_tvalid), .us_tready(us_tready), .us_tdata(us_tdata),
    .fir_ss_tvalid(fir_ss_tvalid), .fir_ss_tready(fir_ss_tready),
    .fir_ss_tdata(fir_ss_tdata), .fir_ss_tlast(fir_ss_tlast),
    .fir_sm_tvalid(fir_sm_tvalid), .fir_sm_tready(fir_sm_tready),
    .fir_sm_tdata(fir_sm_tdata), .fir_sm_tlast(fir_sm_tlast),
    .ds_tvalid(ds_tvalid), .ds_tready(ds_tready), .ds_tdata(ds_tdata),
    .x_cnt(x_cnt), .y_cnt(y_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fir_fn(input logic [31:0] d);
    return d * 32'd3 + 32'h10;
  endfunction

  task automatic idle_inputs();
    cfg_start = 0; done_clr = 0; cfg_len = 0;
    us_tvalid = 0; us_tdata = 0; fir_ss_tready = 0;
    fir_sm_tvalid = 0; fir_sm_tdata = 0; fir_sm_tlast = 0; ds_tready = 0;
  endtask

  // Called at a negedge. bad_tl: Y index with a flipped tlast (-1 = none).
  // abort_x: reset the DUT once this many X have been offered (0 = no abort).
  task automatic run_job(input int len, input int bad_tl, input bit ds_tog,
                         input int abort_x, input bit clr_too);
    logic [31:0] q_fir[$];
    int xi, yi;
    bit fin, x_hs, y_hs;
    exp_q.delete();
    cfg_start = 1; cfg_len = len; done_clr = clr_too;
    @(negedge clk);
    cfg_start = 0; done_clr = 0;
    #1;
    chk("ap_start_set", ap_start, 1);
    chk("ap_idle_run", ap_idle, 0);
    chk("ap_done_run", ap_done, 0);
    chk("err_clr", err, 0);
    chk("x_cnt_clr", x_cnt, 0);
    fin = 0; xi = 0; yi = 0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      us_tvalid = (xi < len);
      us_tdata = 32'(xi + 1);
      fir_ss_tready = 1;
      fir_sm_tvalid = (q_fir.size() > 0);
      fir_sm_tdata = (q_fir.size() > 0) ? q_fir[0] : 32'h0;
      fir_sm_tlast = (yi == len - 1) ^ (yi == bad_tl);
      ds_tready = ds_tog ? ~cyc[0] : 1'b1;
      #1;
      chk("ds_valid", ds_tvalid, fir_sm_tvalid);
      chk("not_done", ap_done, 0);
      y_hs = fir_sm_tvalid && fir_sm_tready;
      if (y_hs) begin
        if (exp_q.size() == 0) chk("y_extra", 1, 0);
        else chk("y_data", ds_tdata, exp_q.pop_front());
        void'(q_fir.pop_front());
        yi++;
        if (yi == len) fin = 1;
      end
      x_hs = us_tvalid && us_tready;
      if (x_hs) begin
        chk("x_tlast", fir_ss_tlast, (xi == len - 1));
        chk("x_data", fir_ss_tdata, 32'(xi + 1));
        q_fir.push_back(fir_fn(us_tdata));
        exp_q.push_back(fir_fn(us_tdata));
        xi++;
      end
      if (abort_x > 0 && xi == abort_x) fin = 1;
      if (!fin) @(negedge clk);
    end
    chk("job_timeout", fin, 1);
    if (abort_x > 0) begin
      rst = 1;
      @(negedge clk);
      rst = 0;
      us_tvalid = 1; fir_sm_tvalid = 1; ds_tready = 1; fir_ss_tready = 1;
      #1;
      chk("abort_idle", ap_idle, 1);
      chk("abort_start", ap_start, 0);
      chk("abort_x_cnt", x_cnt, 0);
      chk("abort_y_cnt", y_cnt, 0);
      chk("abort_gate_x", fir_ss_tvalid, 0);
      chk("abort_gate_y", ds_tvalid, 0);
      idle_inputs();
      exp_q.delete();
    end else begin
      @(posedge clk);
      #1;
      idle_inputs();
      us_tvalid = 1; fir_ss_tready = 1; fir_sm_tvalid = 1; ds_tready = 1;
      @(negedge clk);
      chk("done_set", ap_done, 1);
      chk("done_idle", ap_idle, 1);
      chk("done_x_cnt", x_cnt, len);
      chk("done_y_cnt", y_cnt, len);
      chk("done_err", err, (bad_tl >= 0) ? 32'd1 : 32'd0);
      chk("done_gate_x", us_tready, 0);
      chk("done_gate_y", fir_sm_tready, 0);
      chk("sb_empty", exp_q.size(), 0);
      idle_inputs();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst = 1;
    us_tvalid = 1; fir_ss_tready = 1; fir_sm_tvalid = 1; ds_tready = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_idle", ap_idle, 1);
    chk("rst_start", ap_start, 0);
    chk("rst_done", ap_done, 0);
    chk("rst_err", err, 0);
    chk("rst_x_cnt", x_cnt, 0);
    chk("rst_y_cnt", y_cnt, 0);
    chk("rst_ss_valid", fir_ss_tvalid, 0);
    chk("rst_us_ready", us_tready, 0);
    chk("rst_ds_valid", ds_tvalid, 0);
    chk("rst_sm_ready", fir_sm_tready, 0);

    // zero-length start is ignored
    idle_inputs();
    @(negedge clk);
    cfg_start = 1; cfg_len = 0;
    @(negedge clk);
    cfg_start = 0;
    us_tvalid = 1; fir_ss_tready = 1; fir_sm_tvalid = 1; ds_tready = 1;
    #1;
    chk("len0_idle", ap_idle, 1);
    chk("len0_start", ap_start, 0);
    chk("len0_ss_valid", fir_ss_tvalid, 0);
    chk("len0_ds_valid", ds_tvalid, 0);
    idle_inputs();
    @(negedge clk);

    run_job(4, -1, 0, 0, 0);
    done_clr = 1;
    @(negedge clk);
    done_clr = 0;
    #1;
    chk("clr_done", ap_done, 0);
    chk("clr_idle", ap_idle, 1);
    @(negedge clk);

    run_job(3, -1, 1, 0, 0);
    run_job(4, 1, 0, 0, 0);
    run_job(5, -1, 0, 2, 1);
    @(negedge clk);
    run_job(2, -1, 0, 0, 0);

`ifdef FIR_SCHED_WDOG_EN
    begin
      int cyc;
      cfg_start = 1; cfg_len = 2;
      @(negedge clk);
      cfg_start = 0;
      us_tvalid = 1; us_tdata = 32'h55; fir_ss_tready = 1; ds_tready = 1;
      cyc = 0;
      while (!ap_done && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      chk("wdog_done", ap_done, 1);
      chk("wdog_err", err, 2);
      chk("wdog_x_cnt", x_cnt, 2);
      chk("wdog_y_cnt", y_cnt, 0);
      idle_inputs();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
